rice_csr_counter: RTL
=====================

Name: rice_csr_counter

Overview:
- Owns the 64-bit cycle and instret event counters and drives the counter-value inputs of the U-level CSR block.
- Sits between the core pipeline (retire events) and the CSR blocks.
- Accepts M-level CSR writes to mcycle/minstret (low and high halves) and honours mcountinhibit-style per-counter inhibit bits.
- Outputs are 32-bit halves, ready to wire straight into the cycle/instret/cycleh/instreth read ports.

Parameters:
- RETIRE_WIDTH, 1, maximum instructions retired per cycle. Legal range 1..4.
- CYCLE_RESET, 64'h0, reset value of the cycle counter.
- INSTRET_RESET, 64'h0, reset value of the instret counter.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  asynchronous active-high reset
- i_retire_count  input  $clog2(RETIRE_WIDTH+1)  instructions retired this cycle. Values above RETIRE_WIDTH are illegal.
- i_inhibit_cycle  input  1  freeze the cycle counter (mcountinhibit.CY)
- i_inhibit_instret  input  1  freeze the instret counter (mcountinhibit.IR)
- i_write_valid  input  1  CSR write strobe, single cycle
- i_write_select  input  2  0 = mcycle, 1 = minstret, 2 = mcycleh, 3 = minstreth
- i_write_data  input  32  write value
- o_cycle  output  32  cycle[31:0]
- o_cycleh  output  32  cycle[63:32]
- o_instret  output  32  instret[31:0]
- o_instreth  output  32  instret[63:32]

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is asynchronous and active-high. While i_rst=1, the cycle register holds CYCLE_RESET and the instret register holds INSTRET_RESET, so outputs show the reset halves. The first increment happens on the first rising edge after i_rst deasserts.
- Outputs: driven directly from registers, no combinational path from any input. An update becomes visible the cycle after its edge.
- Cycle counter: increments by 1 every edge unless i_inhibit_cycle=1. Arithmetic is modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFF wraps to 0.
- Instret counter: increments by i_retire_count, zero-extended to 64 bits, unless i_inhibit_instret=1. Modulo 2^64.
- Low-half write (select 0/1):
  - Bits [31:0] take i_write_data.
  - Bits [63:32] keep their current value. No carry is generated from the replaced low half.
  - The increment for that counter is suppressed this cycle.
  - The other counter increments normally.
- High-half write (select 2/3): bits [63:32] take i_write_data. Bits [31:0] still increment normally, but any carry out of the low half is discarded this cycle.
- Inhibit plus write in the same cycle: the write still takes effect. Inhibit only blocks the increment.
- Writes to one counter never affect the other.
- i_retire_count=0 is a legal no-op.
- Reset asserted mid-operation discards any in-flight write or pending carry.
- No internal FSM beyond the counter registers and the optional carry stage.

Optional Feature:
- Macro: RICE_CSR_COUNTER_SPLIT_CARRY_EN.
- Without the macro: each counter is a single 64-bit adder. The high half updates in the same edge as the low-half wrap.
- With the macro (cuts the 64-bit carry chain):
  - Each counter is split into two 32-bit halves plus a 1-bit registered carry.
  - When the low half overflows, the carry flop sets. The high half increments by 1 on the next edge, independent of inhibit.
  - o_cycleh/o_instreth therefore lag the low-half wrap by exactly one cycle.
  - A high-half write in the cycle the pending carry would apply overwrites the high half and clears the carry.
  - A low-half write does not cancel a carry already pending from the previous cycle.
  - Reset clears the carry flops.

Test Plan:
- Reset, then run 10 cycles, no retire, no inhibit -> o_cycle=10, o_cycleh=0, o_instret=0.
- RETIRE_WIDTH=2: retire counts 2,1,0,2 on consecutive cycles -> o_instret=5. Then i_inhibit_instret=1 with count 2 for 3 cycles -> still 5.
- Write mcycle (select 0) = 32'hFFFF_FFFE -> next o_cycle=FFFF_FFFE with no increment that cycle. Two cycles later o_cycle=0, o_cycleh=1. With the macro, o_cycleh=1 appears one cycle after o_cycle=0.
- Write minstreth = 32'h1234_5678 while retire count=1 and low half=5 -> o_instreth=1234_5678, o_instret=6.
- Same-edge write to mcycle while i_inhibit_cycle=1, data 32'hA5 -> o_cycle=A5 and holds thereafter. The instret counter continues unaffected.
- Assert i_rst mid-count with CYCLE_RESET=64'h100 -> o_cycle=100 immediately (asynchronous), o_cycleh=0, pending carry cleared.

Source files
------------

// File: rtl/rice_csr_counter.sv
// rice_csr_counter: 64-bit cycle and instret counters feeding the U-level
// counter CSR read ports, with M-level half-word writes and per-counter inhibit.
// Optional macro RICE_CSR_COUNTER_SPLIT_CARRY_EN splits each counter into two
// 32-bit halves joined by a registered carry, so the high half trails a
// low-half wrap by one cycle.
module rice_csr_counter #(
  parameter int unsigned RETIRE_WIDTH  = 1,
  parameter logic [63:0] CYCLE_RESET   = 64'h0,
  parameter logic [63:0] INSTRET_RESET = 64'h0
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [$clog2(RETIRE_WIDTH+1)-1:0] i_retire_count,
  input  logic                              i_inhibit_cycle,
  input  logic                              i_inhibit_instret,
  input  logic                              i_write_valid,
  input  logic [1:0]                        i_write_select,
  input  logic [31:0]                       i_write_data,
  output logic [31:0]                       o_cycle,
  output logic [31:0]                       o_cycleh,
  output logic [31:0]                       o_instret,
  output logic [31:0]                       o_instreth
);

  // Index 0 is the cycle counter, index 1 is the instret counter.
  localparam logic [63:0] RESET_VAL [2] = '{CYCLE_RESET, INSTRET_RESET};

  logic [31:0] inc [2];
  logic [63:0] ctr_val [2];

  // Per-counter increment amount after inhibit is applied.
  always_comb begin
    inc[0] = {31'd0, ~i_inhibit_cycle};
    inc[1] = i_inhibit_instret ? 32'd0 : 32'(i_retire_count);
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_ctr
    logic wr_low;
    logic wr_high;

    // Select 0/1 address the low halves, 2/3 the high halves.
    assign wr_low  = i_write_valid && (i_write_select == 2'(gi));
    assign wr_high = i_write_valid && (i_write_select == 2'(gi + 2));

`ifdef RICE_CSR_COUNTER_SPLIT_CARRY_EN
    logic [31:0] lo_q, lo_d;
    logic [31:0] hi_q, hi_d;
    logic        carry_q, carry_d;
    logic [32:0] lo_sum;

    // Low half adds the increment; a wrap is parked in the carry flop and
    // applied to the high half one edge later regardless of inhibit. Any
    // write kills the newly generated carry; a high write also overrides
    // the carry being applied this edge.
    always_comb begin
      lo_sum  = {1'b0, lo_q} + {1'b0, inc[gi]};
      lo_d    = lo_sum[31:0];
      hi_d    = hi_q + {31'd0, carry_q};
      carry_d = lo_sum[32];
      if (wr_low) begin
        lo_d    = i_write_data;
        carry_d = 1'b0;
      end
      if (wr_high) begin
        hi_d    = i_write_data;
        carry_d = 1'b0;
      end
    end

    // Counter halves and carry stage, asynchronously reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        lo_q    <= RESET_VAL[gi][31:0];
        hi_q    <= RESET_VAL[gi][63:32];
        carry_q <= 1'b0;
      end else begin
        lo_q    <= lo_d;
        hi_q    <= hi_d;
        carry_q <= carry_d;
      end
    end

    assign ctr_val[gi] = {hi_q, lo_q};
`else
    logic [63:0] cnt_q, cnt_d;
    logic [31:0] lo_inc;

    // Full 64-bit increment; a low write freezes the counter except for the
    // new low word, a high write keeps the low increment but drops its carry.
    always_comb begin
      lo_inc = cnt_q[31:0] + inc[gi];
      cnt_d  = cnt_q + {32'd0, inc[gi]};
      if (wr_low) begin
        cnt_d = {cnt_q[63:32], i_write_data};
      end else if (wr_high) begin
        cnt_d = {i_write_data, lo_inc};
      end
    end

    // Counter register, asynchronously reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        cnt_q <= RESET_VAL[gi];
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign ctr_val[gi] = cnt_q;
`endif
  end

  assign o_cycle    = ctr_val[0][31:0];
  assign o_cycleh   = ctr_val[0][63:32];
  assign o_instret  = ctr_val[1][31:0];
  assign o_instreth = ctr_val[1][63:32];

endmodule
